context_fetcher: RTL and testbench
==================================

Name: context_fetcher

Overview:
- Synthesizable initiator for the byte-wide context-memory read protocol. Drives readM, waits for ready, captures data, and completes the 4-phase return-to-zero handshake.
- Fetches a fixed-length syscall context block, packs the bytes little-endian into words, and streams the words to the LSTM core over a valid/ready interface.
- The memory side is free-running and has no clock, so ready is treated as asynchronous.

Parameters:
- NUM_BYTES, 16, bytes fetched per start; must be a nonzero multiple of WORD_BYTES.
- WORD_BYTES, 4, bytes packed per output word.
- SYNC_STAGES, 2, flop stages on the ready input; minimum 2.

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to fetch one block; sampled only in IDLE.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last word handshake.
- readM  out  1  read request to context memory; registered.
- ready  in  1  memory acknowledge; asynchronous.
- data  in  8  memory byte; stable from before ready rises until the next readM rise.
- word_valid  out  1  output word valid.
- word_ready  in  1  consumer accept.
- word_data  out  8*WORD_BYTES  packed word; byte 0 is the first fetched byte, in bits [7:0].
- word_last  out  1  high with the final word of the block.

Behaviour:
- Reset values: readM=0, busy=0, done=0, word_valid=0, word_last=0, word_data=0, sync chain=0, byte/word counters=0, state=IDLE.
- ready passes through SYNC_STAGES flops to give rdy_s. data is not synchronized; it is sampled only once rdy_s=1, when it is guaranteed stable.
- FSM states:
  - IDLE: on start=1, set busy=1. If rdy_s=0 go to REQ, else go to DRAIN.
  - DRAIN: hold readM=0 until rdy_s=0, then go to REQ. This recovers from a reset or abort that occurred mid-handshake.
  - REQ: readM=1. When rdy_s=1, capture data into byte lane byte_cnt%WORD_BYTES, set readM=0 in the same edge, go to RELEASE.
  - RELEASE: readM=0; wait for rdy_s=0. Then:
    - if the word is complete, go to PUSH;
    - otherwise increment byte_cnt and go to REQ.
  - PUSH: word_valid=1, with word_data and word_last held stable. On word_valid&&word_ready:
    - deassert word_valid;
    - if this was the last word, pulse done and clear busy/counters, going to IDLE;
    - else go to REQ.
- readM never rises while rdy_s=1. readM only falls after rdy_s=1 has been observed.
- Per-byte latency is about 2*(SYNC_STAGES+1) cycles plus memory delays. Minimum per byte is 2*SYNC_STAGES+2 cycles.
- Backpressure: while in PUSH no new request is issued, so readM stays 0. There is no overlap of fetch and push.
- word_last=1 exactly on word index NUM_BYTES/WORD_BYTES-1.
- Counters: byte_cnt width is clog2(NUM_BYTES). It resets to 0 at block end; no wrap within a block.
- start outside IDLE is ignored, with no queuing.
- If start and rstn assertion coincide, reset wins.
- Reset mid-operation forces every output to its reset value immediately. A partial word is discarded.
- done and the word_valid handshake of the last word never coincide; done comes one cycle later.

Test Plan:
- Memory all 0x80, NUM_BYTES=16, word_ready=1 -> 4 words of 0x80808080, word_last on the 4th only, a single done pulse, 16 readM pulses total.
- Memory bytes 0x00..0x0F -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in that order.
- word_ready held 0 for 20 cycles on the first word -> word_valid stays 1, word_data stays 0x03020100, readM stays 0, then fetching resumes after acceptance.
- Assert rstn low after 6 bytes, while ready=1 -> all outputs drop asynchronously. On a restart start, FSM goes to DRAIN with readM=0 until ready falls, then REQ.
- Pulse start 3 times while busy -> exactly 4 words and 1 done; the next start in IDLE triggers a fresh 16-byte fetch.
- Protocol monitor throughout all tests -> readM never 1 while synced ready is 1 at a REQ entry, and each readM falling edge is preceded by ready=1.

Source files
------------

// File: rtl/context_fetcher.sv
// Byte-wide context-memory reader: fetches NUM_BYTES over a 4-phase readM/ready
// handshake, packs them little-endian into words and streams them out on valid/ready.
module context_fetcher #(
    parameter int NUM_BYTES   = 16,
    parameter int WORD_BYTES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    readM,
    input  logic                    ready,
    input  logic [7:0]              data,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word_data,
    output logic                    word_last,
    output logic [2:0]              dbg_state
);

    localparam int CNT_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int WORD_W = 8 * WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_REQ     = 3'd2,
        S_RELEASE = 3'd3,
        S_PUSH    = 3'd4
    } state_t;

    // Handshake: word_valid rises with a complete word and holds word_data/word_last
    // stable until the cycle word_valid && word_ready is seen on a rising edge.

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_s;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]      word_data_q, word_data_d;
    logic                   readm_q, readm_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    int                     lane;
    logic                   word_full;
    logic                   block_end;

    // ready comes from an unclocked memory; data is only looked at once rdy_s is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], ready};
    end

    assign rdy_s     = sync_q[SYNC_STAGES-1];
    assign lane      = int'(byte_cnt_q) % WORD_BYTES;
    assign word_full = (lane == WORD_BYTES - 1);
    assign block_end = (int'(byte_cnt_q) == NUM_BYTES - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            word_data_q <= '0;
            readm_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_data_q <= word_data_d;
            readm_q     <= readm_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_data_d = word_data_q;
        readm_d     = readm_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        last_d      = last_q;
        case (state_q)
            S_IDLE: begin
                readm_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (rdy_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_REQ;
                        readm_d = 1'b1;
                    end
                end
            end
            // A handshake left over from a reset is allowed to finish before we ask again.
            S_DRAIN: begin
                readm_d = 1'b0;
                if (!rdy_s) begin
                    state_d = S_REQ;
                    readm_d = 1'b1;
                end
            end
            S_REQ: begin
                readm_d = 1'b1;
                if (rdy_s) begin
                    word_data_d[lane*8 +: 8] = data;
                    readm_d = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                readm_d = 1'b0;
                if (!rdy_s) begin
                    if (word_full) begin
                        state_d = S_PUSH;
                        valid_d = 1'b1;
                        last_d  = block_end;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        state_d    = S_REQ;
                        readm_d    = 1'b1;
                    end
                end
            end
            S_PUSH: begin
                readm_d = 1'b0;
                valid_d = 1'b1;
                if (word_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (block_end) begin
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        byte_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        if (rdy_s) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_REQ;
                            readm_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                readm_d = 1'b0;
            end
        endcase
    end

    assign readM      = readm_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_valid = valid_q;
    assign word_last  = last_q;
    assign word_data  = word_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_context_fetcher.sv
// Bench for context_fetcher: behavioural async memory, protocol monitor and a
// word scoreboard, driven by a block table plus hand-written corner sequences.
module tb_context_fetcher;

    localparam int NB = 16;
    localparam int WB = 4;
    localparam int NW = NB / WB;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DRAIN = 3'd1;
    localparam logic [2:0] ST_REQ   = 3'd2;
    localparam logic [2:0] ST_PUSH  = 3'd4;

    typedef struct packed {
        logic [7:0]           base;
        logic [7:0]           step;
        int                   ack_dly;
        int                   rel_dly;
        logic [NW-1:0][31:0]  w;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        busy;
    logic        done;
    logic        readM;
    logic        ready;
    logic [7:0]  data;
    logic        word_valid;
    logic        word_ready;
    logic [31:0] word_data;
    logic        word_last;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int readm_rises = 0;
    int done_cnt = 0;
    int word_cnt = 0;
    int ack_cnt = 0;
    int mem_addr = 0;
    int ack_dly = 0;
    int rel_dly = 0;
    logic [7:0]  mem [NB];
    logic [32:0] exp_q[$];
    vec_t        vecs [4];

    context_fetcher #(.NUM_BYTES(NB), .WORD_BYTES(WB), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .readM      (readM),
        .ready      (ready),
        .data       (data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [7:0] s, input int a, input int r,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        vec_t v;
        v.base = b; v.step = s; v.ack_dly = a; v.rel_dly = r;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        return v;
    endfunction

    task automatic load_block(input vec_t v);
        for (int i = 0; i < NB; i++) mem[i] = v.base + v.step * 8'(i);
        ack_dly  = v.ack_dly;
        rel_dly  = v.rel_dly;
        mem_addr = 0;
        for (int w = 0; w < NW; w++) exp_q.push_back({(w == NW - 1), v.w[w]});
    endtask

    // Unclocked memory: answers readM after ack_dly cycles, releases ready rel_dly after readM falls.
    task automatic mem_model();
        forever begin
            @(posedge clk); #1;
            if (readM && !ready) begin
                repeat (ack_dly) begin @(posedge clk); #1; end
                data = mem[mem_addr % NB];
                mem_addr++;
                ack_cnt++;
                @(posedge clk); #1;
                ready = 1'b1;
            end else if (!readM && ready) begin
                repeat (rel_dly) begin @(posedge clk); #1; end
                ready = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic rm_prev = 1'b0;
        logic s1 = 1'b0, s2 = 1'b0, s2_pre = 1'b0, seen = 1'b0;
        logic [32:0] e;
        forever begin
            @(posedge clk);
            s2_pre = s2; s2 = s1; s1 = ready;
            if (!rstn) begin s1 = 1'b0; s2 = 1'b0; s2_pre = 1'b0; end
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                s1 = 1'b0; s2 = 1'b0; seen = 1'b0; rm_prev = readM;
            end else begin
                if (readM && !rm_prev) begin
                    readm_rises++;
                    check("readm_rise_vs_sync_ready", {31'd0, s2_pre}, 32'd0);
                end
                if (!readM && rm_prev) begin
                    check("readm_fall_after_ready", {31'd0, seen}, 32'd1);
                    seen = 1'b0;
                end
                if (readM && ready) seen = 1'b1;
                rm_prev = readM;
                if (word_valid && word_ready) begin
                    word_cnt++;
                    check("sb_word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_word_data", word_data, e[31:0]);
                        check("sb_word_last", {31'd0, word_last}, {31'd0, e[32]});
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_apart_from_valid", {31'd0, word_valid}, 32'd0);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < budget);
        check("done_within_budget", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_readM"}, {31'd0, readM}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_word_valid"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_word_last"}, {31'd0, word_last}, 32'd0);
        check({tag, "_word_data"}, word_data, 32'd0);
        check({tag, "_state"}, {29'd0, dbg_state}, {29'd0, ST_IDLE});
    endtask

    initial begin
        int r0, d0, w0, c0, a0, n;

        vecs[0] = mk(8'h80, 8'h00, 0, 0, 32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080);
        vecs[1] = mk(8'h00, 8'h01, 1, 2, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        vecs[2] = mk(8'hF0, 8'h01, 3, 0, 32'hF3F2F1F0, 32'hF7F6F5F4, 32'hFBFAF9F8, 32'hFFFEFDFC);
        vecs[3] = mk(8'h10, 8'h11, 2, 1, 32'h43322110, 32'h87766554, 32'hCBBAA998, 32'h0FFEEDDC);

        rstn = 1'b0; start = 1'b0; ready = 1'b0; data = 8'h00; word_ready = 1'b1;
        fork
            mem_model();
            monitor();
        join_none

        #22;
        check_reset_outputs("reset");
        @(posedge clk); #1 rstn = 1'b1;
        repeat (3) @(posedge clk);

        for (int t = 0; t < 4; t++) begin
            r0 = readm_rises; d0 = done_cnt; w0 = word_cnt; c0 = cyc;
            load_block(vecs[t]);
            pulse_start();
            @(negedge clk);
            check("blk_busy_after_start", {31'd0, busy}, 32'd1);
            wait_done(4000);
            @(negedge clk);
            check("blk_words", word_cnt - w0, NW);
            check("blk_done_pulses", done_cnt - d0, 1);
            check("blk_readm_pulses", readm_rises - r0, NB);
            check("blk_busy_cleared", {31'd0, busy}, 32'd0);
            check("blk_queue_empty", exp_q.size(), 0);
            check("blk_min_latency", {31'd0, (cyc - c0) >= NB * 6}, 32'd1);
        end

        // Consumer stalls on the first word.
        @(posedge clk); #1 word_ready = 1'b0;
        r0 = readm_rises; w0 = word_cnt;
        load_block(vecs[1]);
        ack_dly = 0; rel_dly = 0;
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!word_valid && n < 1000);
        check("stall_valid_seen", {31'd0, word_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("stall_valid_held", {31'd0, word_valid}, 32'd1);
            check("stall_data_held", word_data, 32'h03020100);
            check("stall_readm_low", {31'd0, readM}, 32'd0);
            check("stall_state_push", {29'd0, dbg_state}, {29'd0, ST_PUSH});
            @(negedge clk);
        end
        @(posedge clk); #1 word_ready = 1'b1;
        wait_done(4000);
        @(negedge clk);
        check("stall_words", word_cnt - w0, NW);
        check("stall_readm_pulses", readm_rises - r0, NB);
        check("stall_queue_empty", exp_q.size(), 0);

        // Extra starts while busy are ignored.
        r0 = readm_rises; d0 = done_cnt; w0 = word_cnt;
        load_block(vecs[0]);
        ack_dly = 1; rel_dly = 1;
        pulse_start();
        repeat (10) @(posedge clk);
        pulse_start();
        repeat (30) @(posedge clk);
        pulse_start();
        repeat (40) @(posedge clk);
        pulse_start();
        @(negedge clk);
        check("ignore_busy_during_starts", {31'd0, busy}, 32'd1);
        wait_done(4000);
        repeat (30) @(negedge clk);
        check("ignore_words", word_cnt - w0, NW);
        check("ignore_done_pulses", done_cnt - d0, 1);
        check("ignore_readm_pulses", readm_rises - r0, NB);
        check("ignore_busy_cleared", {31'd0, busy}, 32'd0);
        check("ignore_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        r0 = readm_rises; d0 = done_cnt; w0 = word_cnt;
        load_block(vecs[3]);
        pulse_start();
        wait_done(4000);
        @(negedge clk);
        check("fresh_words", word_cnt - w0, NW);
        check("fresh_done_pulses", done_cnt - d0, 1);
        check("fresh_readm_pulses", readm_rises - r0, NB);

        // Reset in the middle of the sixth byte handshake, then restart into DRAIN.
        a0 = ack_cnt;
        load_block(vecs[1]);
        ack_dly = 0; rel_dly = 10;
        pulse_start();
        n = 0;
        do begin @(negedge clk); n++; end while (!((ack_cnt - a0) == 6 && ready) && n < 2000);
        check("rst_sixth_ack_seen", {31'd0, (ack_cnt - a0) == 6 && ready}, 32'd1);
        #1 rstn = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk); #1 rstn = 1'b1;
        r0 = readm_rises; d0 = done_cnt; w0 = word_cnt;
        load_block(vecs[1]);
        ack_dly = 0; rel_dly = 10;
        repeat (3) @(posedge clk);
        pulse_start();
        @(negedge clk);
        check("restart_state_drain", {29'd0, dbg_state}, {29'd0, ST_DRAIN});
        check("restart_ready_still_high", {31'd0, ready}, 32'd1);
        rel_dly = 0;
        n = 0;
        while (dbg_state != ST_REQ && n < 200) begin
            check("drain_readm_low", {31'd0, readM}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("drain_reaches_req", {29'd0, dbg_state}, {29'd0, ST_REQ});
        check("ready_low_at_req", {31'd0, ready}, 32'd0);
        wait_done(4000);
        @(negedge clk);
        check("restart_words", word_cnt - w0, NW);
        check("restart_done_pulses", done_cnt - d0, 1);
        check("restart_readm_pulses", readm_rises - r0, NB);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
